seg_scroll_monitor: RTL and testbench

Receive-side monitor for the four-digit scrolling "HI" seven-segment display bus. It samples the active-low segment buses hex3..hex0 and filters out transients shorter than a programmable stability window. Each stable frame is decoded to per-digit character codes and a scroll position. The block tracks whether frames advance in the legal rotation order and reports lock, sequence errors and an error count. It sits beside the display driver as a self-check or on-board loopback monitor.

---
 rtl/seg_scroll_monitor.sv | 171 +++++++++++++++++
 tb/tb_seg_scroll_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scroll_monitor.sv
// seg_scroll_monitor
// Receive-side monitor for the four-digit scrolling "HI" seven-segment bus.
// Filters transients, decodes stable frames into per-digit codes and a scroll
// position, and tracks rotation lock with sequence-error reporting.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// UNLOCKED | no usable history; waiting for a known frame
// TRACKING | counting consecutive in-order known frames (run)
// LOCKED   | LOCK_FRAMES in-order frames seen; violations raise seq_err

module seg_scroll_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter int LOCK_FRAMES   = 3
) (
   input  logic       clock_50,
   input  logic       rs_n,
   input  logic [6:0] hex0,
   input  logic [6:0] hex1,
   input  logic [6:0] hex2,
   input  logic [6:0] hex3,
   output logic       frame_valid,
   output logic [7:0] frame_code,
   output logic       pos_valid,
   output logic [1:0] position,
   output logic       locked,
   output logic       seq_err,
   output logic [7:0] err_count
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int RW = $clog2(LOCK_FRAMES + 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_H     = 7'b0001001;
   localparam logic [6:0] SEG_I     = 7'b1111001;
   localparam logic [27:0] FRAME_BLANK = {4{SEG_BLANK}};

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      TRACKING = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   state_t         state;
   logic [RW-1:0]  run;
   logic [27:0]    samp;
   logic [27:0]    last_frame;
   logic [CW-1:0]  stab_cnt;

   logic [27:0]    bus_in;
   logic [CW-1:0]  stab_cnt_nxt;
   logic           accept;
   logic [7:0]     dec_code;
   logic           dec_known;
   logic [1:0]     dec_pos;
   logic           in_order;

   function automatic logic [1:0] digit_code(input logic [6:0] seg);
      case (seg)
         SEG_BLANK: digit_code = 2'd0;
         SEG_H:     digit_code = 2'd1;
         SEG_I:     digit_code = 2'd2;
         default:   digit_code = 2'd3;
      endcase
   endfunction

   assign bus_in = {hex3, hex2, hex1, hex0};

   // Stability filter: next count and acceptance decision for this edge.
   always_comb begin
      stab_cnt_nxt = '0;
      if (bus_in == samp) begin
         if (stab_cnt == CW'(STABLE_CYCLES))
            stab_cnt_nxt = stab_cnt;
         else
            stab_cnt_nxt = stab_cnt + 1'b1;
      end
      accept = (bus_in == samp) && (stab_cnt_nxt == CW'(STABLE_CYCLES)) &&
               (samp != last_frame);
   end

   // Decode the registered sample into digit codes and a scroll position.
   always_comb begin
      dec_code  = {digit_code(samp[27:21]), digit_code(samp[20:14]),
                   digit_code(samp[13:7]),  digit_code(samp[6:0])};
      dec_known = 1'b1;
      dec_pos   = 2'd0;
      case (dec_code)
         8'h09:   dec_pos = 2'd0;
         8'h24:   dec_pos = 2'd1;
         8'h90:   dec_pos = 2'd2;
         8'h42:   dec_pos = 2'd3;
         default: dec_known = 1'b0;
      endcase
      in_order = dec_known && (dec_pos == 2'(position + 2'd1));
   end

   // Input register, filter state, decoded outputs and the lock FSM.
   always_ff @(posedge clock_50) begin
      if (!rs_n) begin
         samp        <= FRAME_BLANK;
         last_frame  <= FRAME_BLANK;
         stab_cnt    <= '0;
         state       <= UNLOCKED;
         run         <= '0;
         frame_valid <= 1'b0;
         frame_code  <= 8'h00;
         pos_valid   <= 1'b0;
         position    <= 2'd0;
         locked      <= 1'b0;
         seq_err     <= 1'b0;
         err_count   <= 8'h00;
      end else begin
         samp        <= bus_in;
         stab_cnt    <= stab_cnt_nxt;
         frame_valid <= accept;
         seq_err     <= 1'b0;
         if (accept) begin
            last_frame <= samp;
            frame_code <= dec_code;
            pos_valid  <= dec_known;
            if (dec_known)
               position <= dec_pos;
            case (state)
               UNLOCKED: begin
                  if (dec_known) begin
                     state <= TRACKING;
                     run   <= RW'(1);
                  end
               end
               TRACKING: begin
                  if (!dec_known) begin
                     state <= UNLOCKED;
                     run   <= '0;
                  end else if (in_order) begin
                     run <= run + 1'b1;
                     if (run == RW'(LOCK_FRAMES - 1)) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else begin
                     run <= RW'(1);
                  end
               end
               LOCKED: begin
                  if (!in_order) begin
                     seq_err <= 1'b1;
                     locked  <= 1'b0;
                     if (err_count != 8'hFF)
                        err_count <= err_count + 8'h01;
                     if (dec_known) begin
                        state <= TRACKING;
                        run   <= RW'(1);
                     end else begin
                        state <= UNLOCKED;
                        run   <= '0;
                     end
                  end
               end
               default: begin
                  state  <= UNLOCKED;
                  run    <= '0;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seg_scroll_monitor.sv
// Directed self-checking bench for seg_scroll_monitor (STABLE_CYCLES=4, LOCK_FRAMES=3).
module tb_seg_scroll_monitor;

   localparam logic [6:0] B = 7'b1111111;
   localparam logic [6:0] H = 7'b0001001;
   localparam logic [6:0] I = 7'b1111001;

   localparam logic [27:0] P0   = {B, B, I, H};
   localparam logic [27:0] P1   = {B, I, H, B};
   localparam logic [27:0] P2   = {I, H, B, B};
   localparam logic [27:0] P3   = {H, B, B, I};
   localparam logic [27:0] HHHH = {H, H, H, H};
   localparam logic [27:0] BLNK = {B, B, B, B};

   logic        clock_50 = 1'b0;
   logic        rs_n;
   logic [27:0] bus;
   logic        frame_valid, pos_valid, locked, seq_err;
   logic [7:0]  frame_code, err_count;
   logic [1:0]  position;

   int tests = 0;
   int fails = 0;
   int fv_cnt = 0;
   int se_cnt = 0;
   int se_alone = 0;
   int fv_base, se_base;

   always #10 clock_50 = ~clock_50;

   seg_scroll_monitor #(.STABLE_CYCLES(4), .LOCK_FRAMES(3)) dut (
      .clock_50    (clock_50),
      .rs_n        (rs_n),
      .hex0        (bus[6:0]),
      .hex1        (bus[13:7]),
      .hex2        (bus[20:14]),
      .hex3        (bus[27:21]),
      .frame_valid (frame_valid),
      .frame_code  (frame_code),
      .pos_valid   (pos_valid),
      .position    (position),
      .locked      (locked),
      .seq_err     (seq_err),
      .err_count   (err_count)
   );

   // Pulse counters sampled away from the active edge.
   always @(negedge clock_50) begin
      if (frame_valid) fv_cnt++;
      if (seq_err) se_cnt++;
      if (seq_err && !frame_valid) se_alone++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clock_50);
      #1;
   endtask

   task automatic hold(input logic [27:0] f, input int n);
      bus = f;
      edges(n);
   endtask

   initial begin
      rs_n = 1'b0;
      bus  = BLNK;
      edges(3);
      chk("rst_fv",   32'(frame_valid), 32'd0);
      chk("rst_code", 32'(frame_code),  32'h00);
      chk("rst_pv",   32'(pos_valid),   32'd0);
      chk("rst_pos",  32'(position),    32'd0);
      chk("rst_lock", 32'(locked),      32'd0);
      chk("rst_se",   32'(seq_err),     32'd0);
      chk("rst_err",  32'(err_count),   32'd0);
      rs_n = 1'b1;

      // All-blank bus must not produce a frame.
      hold(BLNK, 20);
      chk("blank_no_fv", 32'(fv_cnt), 32'd0);
      chk("blank_code",  32'(frame_code), 32'h00);

      // Exact acceptance latency for pos 0.
      bus = P0;
      edges(4);
      chk("lat_early", 32'(frame_valid), 32'd0);
      edges(1);
      chk("lat_fv",   32'(frame_valid), 32'd1);
      chk("lat_code", 32'(frame_code),  32'h09);
      chk("lat_pos",  32'(position),    32'd0);
      chk("lat_pv",   32'(pos_valid),   32'd1);
      chk("lat_lock", 32'(locked),      32'd0);
      edges(1);
      chk("fv_width", 32'(frame_valid), 32'd0);
      edges(4);

      // In-order rotation with wrap.
      hold(P1, 10);
      chk("p1_code", 32'(frame_code), 32'h24);
      chk("p1_lock", 32'(locked), 32'd0);
      hold(P2, 10);
      chk("p2_code", 32'(frame_code), 32'h90);
      chk("p2_lock", 32'(locked), 32'd1);
      hold(P3, 10);
      chk("p3_code", 32'(frame_code), 32'h42);
      chk("p3_pos",  32'(position), 32'd3);
      hold(P0, 10);
      chk("wrap_lock", 32'(locked), 32'd1);
      chk("wrap_pos",  32'(position), 32'd0);
      chk("wrap_err",  32'(err_count), 32'd0);
      chk("rot_fv_cnt", 32'(fv_cnt), 32'd5);
      hold(P1, 10);

      // Out-of-order frame while locked.
      se_base = se_cnt;
      hold(P3, 10);
      chk("ooo_se",   32'(se_cnt - se_base), 32'd1);
      chk("ooo_lock", 32'(locked), 32'd0);
      chk("ooo_err",  32'(err_count), 32'd1);
      hold(P0, 10);
      chk("relock_a", 32'(locked), 32'd0);
      hold(P1, 10);
      chk("relock_b", 32'(locked), 32'd1);

      // Short glitch is filtered.
      fv_base = fv_cnt;
      se_base = se_cnt;
      hold(HHHH, 3);
      hold(P1, 10);
      chk("glitch_fv",   32'(fv_cnt - fv_base), 32'd0);
      chk("glitch_se",   32'(se_cnt - se_base), 32'd0);
      chk("glitch_lock", 32'(locked), 32'd1);

      // Held unknown frame while locked.
      hold(HHHH, 10);
      chk("unk_code", 32'(frame_code), 32'h55);
      chk("unk_pv",   32'(pos_valid), 32'd0);
      chk("unk_pos",  32'(position), 32'd1);
      chk("unk_se",   32'(se_cnt - se_base), 32'd1);
      chk("unk_lock", 32'(locked), 32'd0);
      chk("unk_err",  32'(err_count), 32'd2);

      // Relock, violate once more, relock to get err_count=3 while locked.
      hold(P0, 10);
      hold(P1, 10);
      hold(P2, 10);
      hold(P0, 10);
      hold(P1, 10);
      hold(P2, 10);
      chk("pre_rst_lock", 32'(locked), 32'd1);
      chk("pre_rst_err",  32'(err_count), 32'd3);
      chk("se_coincident", 32'(se_alone), 32'd0);

      // Reset with a pending frame under stability count.
      bus = P3;
      edges(2);
      rs_n = 1'b0;
      edges(1);
      rs_n = 1'b1;
      chk("mid_rst_lock", 32'(locked), 32'd0);
      chk("mid_rst_err",  32'(err_count), 32'd0);
      chk("mid_rst_code", 32'(frame_code), 32'h00);
      chk("mid_rst_pos",  32'(position), 32'd0);
      edges(4);
      chk("post_rst_early", 32'(frame_valid), 32'd0);
      edges(1);
      chk("post_rst_fv",   32'(frame_valid), 32'd1);
      chk("post_rst_code", 32'(frame_code), 32'h42);
      chk("post_rst_pos",  32'(position), 32'd3);
      edges(5);

      // Error counter saturation: each iteration is one violation then relock at pos 1.
      hold(P0, 6);
      hold(P1, 6);
      chk("sat_start_lock", 32'(locked), 32'd1);
      for (int k = 0; k < 255; k++) begin
         hold(P3, 6);
         hold(P0, 6);
         hold(P1, 6);
      end
      chk("sat_255", 32'(err_count), 32'd255);
      se_base = se_cnt;
      hold(P3, 6);
      chk("sat_hold", 32'(err_count), 32'd255);
      chk("sat_se",   32'(se_cnt - se_base), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
